// File: rtl/bresenham_line_engine_if.sv
// Pixel-bus / segment-request bundle for bresenham_line_engine.
// The master side is the Bresenham controller plus the frame-buffer writer
// (it drives the request and pix_ready); the slave side is the engine.
// Optional macro BLA_PIX_COUNT_EN adds the pix_count signal.
interface bresenham_line_engine_if;
    logic       draw_en;
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
    logic       pix_ready;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_valid;
    logic       draw_done;
    logic       busy;
`ifdef BLA_PIX_COUNT_EN
    logic [8:0] pix_count;

    modport master (
        output draw_en, x0, y0, x1, y1, pix_ready,
        input  pix_x, pix_y, pix_valid, draw_done, busy, pix_count
    );
    modport slave (
        input  draw_en, x0, y0, x1, y1, pix_ready,
        output pix_x, pix_y, pix_valid, draw_done, busy, pix_count
    );
`else
    modport master (
        output draw_en, x0, y0, x1, y1, pix_ready,
        input  pix_x, pix_y, pix_valid, draw_done, busy
    );
    modport slave (
        input  draw_en, x0, y0, x1, y1, pix_ready,
        output pix_x, pix_y, pix_valid, draw_done, busy
    );
`endif
endinterface

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: latches one segment, walks the integer error
// path and hands out one pixel per accepted pixel-bus transfer, then pulses
// draw_done. Optional macro BLA_PIX_COUNT_EN adds the accepted-pixel counter.
module bresenham_line_engine (
    input  logic                    clk,
    input  logic                    rst,
    bresenham_line_engine_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, PLOT, DONE} state_t;

    state_t state, state_nx;

    // Walk state: current point, end point, step magnitudes/directions, error.
    logic [7:0]         cx, cy, ex, ey;
    logic [8:0]         dx;
    logic signed [9:0]  dy;
    logic               sx_neg, sy_neg;
    logic signed [10:0] err;

    // Segment setup values computed straight from the request inputs.
    logic [7:0]         adx, ady;
    logic signed [9:0]  dy_ld;
    logic signed [10:0] err_ld;

    // One Bresenham step.
    logic               accept, at_end, step_x, step_y;
    logic signed [11:0] e2, dx_w, dy_w;
    logic signed [10:0] add_x, add_y, err_nx;

    // Setup arithmetic for LOAD: dx=|x1-x0|, dy=-|y1-y0|, err=dx+dy.
    always_comb begin
        adx    = (bus.x1 >= bus.x0) ? (bus.x1 - bus.x0) : (bus.x0 - bus.x1);
        ady    = (bus.y1 >= bus.y0) ? (bus.y1 - bus.y0) : (bus.y0 - bus.y1);
        dy_ld  = -$signed({2'b00, ady});
        err_ld = $signed({3'b000, adx}) + $signed({dy_ld[9], dy_ld});
    end

    // Step decision; both comparisons use the pre-update error.
    always_comb begin
        accept = (state == PLOT) && bus.pix_ready;
        at_end = (cx == ex) && (cy == ey);
        e2     = $signed({err, 1'b0});
        dx_w   = $signed({3'b000, dx});
        dy_w   = $signed({{2{dy[9]}}, dy});
        step_x = (e2 >= dy_w);
        step_y = (e2 <= dx_w);
        add_x  = step_x ? $signed({dy[9], dy}) : 11'sd0;
        add_y  = step_y ? $signed({2'b00, dx}) : 11'sd0;
        err_nx = err + add_x + add_y;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and state-decoded outputs; nothing here depends on pix_ready
    // except the PLOT->DONE transition, so pix_valid has no path from it.
    always_comb begin
        state_nx      = state;
        bus.pix_valid = 1'b0;
        bus.pix_x     = 8'd0;
        bus.pix_y     = 8'd0;
        bus.draw_done = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.draw_en) state_nx = LOAD;
            end
            LOAD: state_nx = PLOT;
            PLOT: begin
                bus.pix_valid = 1'b1;
                bus.pix_x     = cx;
                bus.pix_y     = cy;
                if (accept && at_end) state_nx = DONE;
            end
            DONE: begin
                bus.draw_done = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch the request in LOAD, advance one step per accepted
    // pixel that is not the end point; everything else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx     <= 8'd0;
            cy     <= 8'd0;
            ex     <= 8'd0;
            ey     <= 8'd0;
            dx     <= 9'd0;
            dy     <= 10'sd0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
            err    <= 11'sd0;
        end else if (state == LOAD) begin
            cx     <= bus.x0;
            cy     <= bus.y0;
            ex     <= bus.x1;
            ey     <= bus.y1;
            dx     <= {1'b0, adx};
            dy     <= dy_ld;
            sx_neg <= !(bus.x0 < bus.x1);
            sy_neg <= !(bus.y0 < bus.y1);
            err    <= err_ld;
        end else if (accept && !at_end) begin
            err <= err_nx;
            if (step_x) cx <= sx_neg ? cx - 8'd1 : cx + 8'd1;
            if (step_y) cy <= sy_neg ? cy - 8'd1 : cy + 8'd1;
        end
    end

`ifdef BLA_PIX_COUNT_EN
    logic [8:0] cnt;

    // Accepted-pixel counter: zero from the start of LOAD, holds through DONE
    // and IDLE until the next request is taken.
    always_ff @(posedge clk) begin
        if (rst)                                            cnt <= 9'd0;
        else if ((state == IDLE && bus.draw_en) || state == LOAD) cnt <= 9'd0;
        else if (accept)                                    cnt <= cnt + 9'd1;
    end

    assign bus.pix_count = cnt;
`endif

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed bench for bresenham_line_engine: hand-computed pixel sequences,
// cycle timing, backpressure, input latching, mid-line reset and re-arm.
module tb_bresenham_line_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bresenham_line_engine_if bus();

    bresenham_line_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int qx[$];
    int qy[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one segment with the controller protocol and check pixels/timing
    // against qx/qy. The request inputs are scrambled once PLOT starts.
    task automatic run_seg(input string nm, input int a, input int b, input int c,
                           input int d, input int stall_at, input int stall_len);
        int idx = 0;
        int k = 0;
        int stalled = 0;
        int first_k = -1;
        int done_k = -1;
        bus.x0 = a[7:0];
        bus.y0 = b[7:0];
        bus.x1 = c[7:0];
        bus.y1 = d[7:0];
        bus.draw_en = 1'b1;
        bus.pix_ready = 1'b1;
        while (done_k < 0 && k < 600) begin
            step;
            k++;
            if (k == 1) begin
                chk({nm, " busy@load"}, int'(bus.busy), 1);
                chk({nm, " valid@load"}, int'(bus.pix_valid), 0);
`ifdef BLA_PIX_COUNT_EN
                chk({nm, " cnt@load"}, int'(bus.pix_count), 0);
`endif
            end
            if (k == 2) begin
                bus.x0 = ~c[7:0];
                bus.y0 = ~d[7:0];
                bus.x1 = ~a[7:0];
                bus.y1 = ~b[7:0];
            end
            if (bus.pix_valid) begin
                if (first_k < 0) first_k = k;
                if (idx < qx.size()) begin
                    chk($sformatf("%s px%0d.x", nm, idx), int'(bus.pix_x), qx[idx]);
                    chk($sformatf("%s px%0d.y", nm, idx), int'(bus.pix_y), qy[idx]);
                end else begin
                    chk({nm, " extra pixel"}, idx, qx.size() - 1);
                end
                if (idx == stall_at && stalled < stall_len) begin
                    bus.pix_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.pix_ready = 1'b1;
                    idx++;
                end
            end
            if (bus.draw_done) begin
                done_k = k;
                bus.draw_en = 1'b0;
`ifdef BLA_PIX_COUNT_EN
                chk({nm, " cnt@done"}, int'(bus.pix_count), qx.size());
`endif
            end
        end
        chk({nm, " done seen"}, int'(done_k > 0), 1);
        chk({nm, " first px cycle"}, first_k, 2);
        chk({nm, " done cycle"}, done_k, qx.size() + 2 + stall_len);
        chk({nm, " px count"}, idx, qx.size());
        step;
        chk({nm, " done pulse 1cy"}, int'(bus.draw_done), 0);
        chk({nm, " idle after"}, int'(bus.busy), 0);
        step;
        chk({nm, " no rearm"}, int'(bus.busy), 0);
    endtask

    initial begin
        int bad;
        bus.draw_en = 1'b0;
        bus.x0 = 8'd0;
        bus.y0 = 8'd0;
        bus.x1 = 8'd0;
        bus.y1 = 8'd0;
        bus.pix_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step;
        chk("rst valid", int'(bus.pix_valid), 0);
        chk("rst done", int'(bus.draw_done), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst pix_x", int'(bus.pix_x), 0);
        chk("rst pix_y", int'(bus.pix_y), 0);
`ifdef BLA_PIX_COUNT_EN
        chk("rst cnt", int'(bus.pix_count), 0);
`endif
        rst = 1'b0;
        step;

        qx = '{0, 1, 2, 3};        qy = '{0, 0, 0, 0};
        run_seg("horiz", 0, 0, 3, 0, -1, 0);

        qx = '{2, 2, 1, 1, 0, 0};  qy = '{5, 4, 3, 2, 1, 0};
        run_seg("steep", 2, 5, 0, 0, -1, 0);

        qx = '{10, 11, 12, 13};    qy = '{10, 11, 11, 12};
        run_seg("bp", 10, 10, 13, 12, 1, 3);

`ifdef BLA_PIX_COUNT_EN
        qx.delete();
        qy.delete();
        for (int i = 0; i < 256; i++) begin
            qx.push_back(i);
            qy.push_back(0);
        end
        run_seg("long", 0, 0, 255, 0, -1, 0);
`endif

        qx = '{7};                 qy = '{7};
        run_seg("point", 7, 7, 7, 7, -1, 0);

        // Mid-line reset on (0,0)->(200,50): pixels at samples 2..6 are
        // accepted, sample 7 shows the sixth pixel (5,1), then rst.
        bus.x0 = 8'd0;
        bus.y0 = 8'd0;
        bus.x1 = 8'd200;
        bus.y1 = 8'd50;
        bus.pix_ready = 1'b1;
        bus.draw_en = 1'b1;
        for (int k = 1; k <= 7; k++) step;
        chk("rstmid valid pre", int'(bus.pix_valid), 1);
        chk("rstmid x pre", int'(bus.pix_x), 5);
        chk("rstmid y pre", int'(bus.pix_y), 1);
        rst = 1'b1;
        bus.draw_en = 1'b0;
        step;
        chk("rstmid valid", int'(bus.pix_valid), 0);
        chk("rstmid busy", int'(bus.busy), 0);
        chk("rstmid done", int'(bus.draw_done), 0);
        chk("rstmid pix_x", int'(bus.pix_x), 0);
        chk("rstmid pix_y", int'(bus.pix_y), 0);
`ifdef BLA_PIX_COUNT_EN
        chk("rstmid cnt", int'(bus.pix_count), 0);
`endif
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            step;
            if (bus.draw_done || bus.busy) bad++;
        end
        chk("rstmid quiet", bad, 0);

        qx = '{1, 2};              qy = '{1, 2};
        run_seg("after rst", 1, 1, 2, 2, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bresenham_line_engine.md
# bresenham_line_engine

Line rasteriser directly downstream of the Bresenham controller. Accepts one segment (x0,y0)→(x1,y1) under the level-held `draw_en` handshake. Walks the integer Bresenham error path and emits one pixel coordinate per accepted pixel-bus transfer to the frame-buffer writer. Pulses `draw_done` once the end point has been accepted.

## Interface
- (no parameters; coordinate width fixed at 8 bits to match the 256×256 canvas)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-high
- draw_en  in  1  segment request; held high by controller until it sees `draw_done`
- x0, y0, x1, y1  in  8 each  segment end points, unsigned
- pix_ready  in  1  downstream accepts the current pixel this cycle
- pix_x, pix_y  out  8 each  current pixel coordinate
- pix_valid  out  1  `pix_x`/`pix_y` hold a valid pixel
- draw_done  out  1  one-cycle pulse: segment complete
- busy  out  1  high in every state except IDLE
- pix_count  out  9  pixels accepted in the current segment (only with `BLA_PIX_COUNT_EN`)

## Operation
- States: IDLE, LOAD, PLOT, DONE.
- **IDLE:**
  - All outputs 0.
  - `draw_en`=1 → LOAD.
- **LOAD:** register the following from the inputs:
  - cx=x0, cy=y0, ex=x1, ey=y1
  - dx=|x1−x0| (9-bit unsigned)
  - dy=−|y1−y0| (10-bit signed)
  - sx=+1 if x0<x1 else −1; sy=+1 if y0<y1 else −1
  - err=dx+dy (11-bit signed)
  - Then → PLOT.
- **PLOT:**
  - `pix_valid`=1; `pix_x`=cx, `pix_y`=cy.
  - On `pix_valid && pix_ready`:
    - If cx==ex and cy==ey → DONE.
    - Otherwise, with e2=2·err (12-bit signed), compute both terms from the pre-update err:
      - if e2≥dy: err+=dy, cx+=sx.
      - if e2≤dx: err+=dx, cy+=sy.
  - Without `pix_ready`, the pixel and all internal state hold unchanged.
- **DONE:** `draw_done`=1 for exactly one cycle, then → IDLE.
- **Input latching:** inputs are sampled only in LOAD. Changes to x0..y1 or a drop of `draw_en` during PLOT/DONE are ignored; the segment always completes.
- **Degenerate segment:** x0==x1 and y0==y1 emits exactly one pixel.
- **Arithmetic:**
  - cx/cy stay within 0..255 by construction; no wrap is possible since the walk terminates at the end point.
  - Pixels per segment = max(|dx|,|dy|)+1, so at most 256.
- **Reset:** `rst` in any state, including mid-PLOT, forces IDLE on the next edge and clears all registers. No `draw_done` is issued for the aborted segment.
- **Re-arm:** after DONE, IDLE starts a new segment on the first cycle `draw_en` is high. The controller's WAIT state guarantees at least one cycle of `draw_en`=0.

## Timing
- Reset values: `pix_x`=`pix_y`=0, `pix_valid`=0, `draw_done`=0, `busy`=0, `pix_count`=0.
- `draw_en` first seen high in IDLE at cycle N:
  - LOAD at N+1.
  - First pixel valid at N+2.
- With `pix_ready` held at 1, one pixel is emitted per cycle.
- The last pixel is accepted at cycle M; `draw_done` is high at M+1; IDLE at M+2.
- Total latency with no backpressure = pixels + 3 cycles from `draw_en` to IDLE.
- All outputs are registered or decoded from state only; no combinational path from `pix_ready` to `pix_valid`.

## Configuration
- `BLA_PIX_COUNT_EN`: defined → `pix_count` port and counter present.
  - Cleared in LOAD; increments on each accepted pixel.
  - Holds its final value through DONE; cleared by `rst` or the next LOAD.
  - Undefined → port and counter absent; all other behaviour identical.

## Test plan
- Horizontal (0,0)→(3,0), `pix_ready`=1, `draw_en` seen at cycle N:
  - Pixels (0,0),(1,0),(2,0),(3,0) on cycles N+2..N+5.
  - `draw_done` at N+6 only; `busy`=0 at N+7.
- Steep reverse (2,5)→(0,0):
  - Exact sequence (2,5),(2,4),(1,3),(1,2),(0,1),(0,0), then one `draw_done` pulse.
- Backpressure on (10,10)→(13,12):
  - Hold `pix_ready`=0 for 3 cycles on pixel 2.
  - (11,11) stays stable with `pix_valid`=1; final sequence (10,10),(11,11),(12,11),(13,12) unchanged.
- Point (7,7)→(7,7):
  - Exactly one pixel (7,7), then `draw_done`.
  - Holding `draw_en`=1 until `draw_done` causes no second segment when `draw_en` drops in the following cycle.
- Reset mid-line (0,0)→(200,50):
  - Assert `rst` after 5 pixels; next cycle all outputs 0, no `draw_done`.
  - New request (1,1)→(2,2) then yields (1,1),(2,2).
- With `BLA_PIX_COUNT_EN`, (0,0)→(255,0):
  - `pix_count`=256 at `draw_done`.
  - `pix_count`=0 one cycle into the next LOAD.
